// File: rtl/fifo_param_sync_pkg.sv
// Shared helpers for the parametrised synchronous FIFO.
// Derives the width needed to hold an occupancy of 0..DEPTH.
package fifo_param_sync_pkg;

    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// Register-array storage for fifo_param_sync.
// One synchronous write port, one asynchronous read port.
module fifo_param_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with programmable levels and flush.
// Define FIFO_FWFT_EN for first-word-fall-through read mode.
module fifo_param_sync
    import fifo_param_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = clog2_cnt(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  clr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_level);
    assign almost_empty = (count <= ae_level);

    always_comb begin
        clr    = reset || flush;
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (!clr) begin
            rd_acc = read_en && !empty;
            wr_acc = write_en && (!full || rd_acc);
        end
    end

    fifo_param_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overflow  <= write_en && !wr_acc;
            underflow <= read_en && !rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_rdata;
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_rdata;
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: doc/fifo_param_sync.md
Name: fifo_param_sync

Overview:
Parametrised single-clock synchronous FIFO. Successor to the fixed FIFO:
- generic data width and any depth ≥ 2, including non-power-of-two depths;
- run-time programmable almost-full and almost-empty levels;
- occupancy count output and a synchronous flush;
- optional first-word-fall-through (FWFT) read mode.

Sits between producer and consumer logic in one clock domain.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 16, number of storage entries; any integer ≥ 2
CNT_W, $clog2(DEPTH+1), width of count and level ports (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents
write_en  input  1  write request
read_en  input  1  read request
data_in  input  DATA_WIDTH  write data
af_level  input  CNT_W  almost-full threshold
ae_level  input  CNT_W  almost-empty threshold
data_out  output  DATA_WIDTH  read data
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset: one clock, clk, rising-edge only; reset is synchronous and active-high.
  - While reset is high at an edge: wr_ptr, rd_ptr, count, data_out, overflow and underflow all go to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1; almost_full=(0>=af_level).
  - Storage contents are not reset.
- Priority: reset > flush > read/write.
- Flush: same effect as reset on pointers, count and data_out. A write or read in the flush cycle is dropped with no overflow/underflow pulse.
- Flag derivation: full, empty, almost_full and almost_empty are combinational compares of the registered count. Levels are sampled continuously.
- Write acceptance:
  - Accepted when write_en && (!full || read accepted in the same cycle).
  - Otherwise, with write_en high, overflow=1 on the next cycle.
- Read acceptance:
  - Accepted when read_en && !empty.
  - Otherwise, with read_en high, underflow=1 on the next cycle.
  - A simultaneous write to an empty FIFO does not make the read valid.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither. Simultaneous read and write at full: both accepted, count stays at DEPTH.
- Pointers: increment on acceptance; wrap from DEPTH−1 to 0 by explicit compare, not binary rollover.
- Standard read mode: on an accepted read, data_out <= mem[rd_ptr] at that edge, i.e. valid the cycle after read_en. data_out holds its value between reads and on rejected reads.
- Pulse timing: overflow and underflow are registered; high for exactly one cycle per rejected request.
- Level values: af_level > DEPTH means almost_full is never asserted. ae_level ≥ DEPTH means almost_empty is always asserted.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - read_en pops the displayed word; the next word appears in the same cycle the pointer advances.
  - Flag, count and error rules are unchanged.
- Undefined: the standard registered read mode described in Behaviour.

Decomposition:
- Shared package pkg: no types are required. Define the CNT_W derivation expression there as a reusable macro-free function clog2_cnt(depth).
- One sub-module: fifo_param_mem, a 1-write/1-read register-array storage with synchronous write and asynchronous read, parametrised on DATA_WIDTH and DEPTH.
- Control logic (pointers, count, flags, errors, output register) stays in fifo_param_sync.

Test Plan:
1. DATA_WIDTH=8, DEPTH=6, af_level=5, ae_level=1.
   - Write 0x01..0x06 -> count reaches 6, full=1; almost_full asserted from count=5.
   - A 7th write -> overflow pulse of 1 cycle, count stays 6.
2. From full, read 6 words -> data_out sequence 0x01..0x06, each one cycle after its read_en; empty=1.
   - A 7th read -> underflow pulse; data_out holds 0x06.
3. Wrap-around, 20 cycles of write+read at count=3 -> data order preserved across pointer wrap 5->0, count constant at 3.
4. Full plus simultaneous read and write -> no overflow, count 6.
   - Empty plus simultaneous read and write -> underflow=1, count 1.
5. Mid-operation control:
   - flush at count=4 with write_en=1 -> count=0, empty=1, no overflow.
   - reset asserted mid-burst -> all outputs at their reset values on the next edge.
6. With FIFO_FWFT_EN defined: write 0xA5 to empty FIFO -> data_out=0xA5 the next cycle with no read_en; read_en -> data_out=0 and empty=1 after the edge.
